// File: rtl/ita_tile_scheduler.sv
// ITA tile scheduler: issues one calc_en per (outer, inner) tile with credit-based FIFO throttling.
// Optional perf counters enabled by defining ITA_TILE_SCHED_PERF_EN.
module ita_tile_scheduler #(
    parameter int unsigned CntW      = 8,
    parameter int unsigned PipeDepth = 10,
    parameter int unsigned FifoDepth = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            cfg_valid_i,
    output logic            cfg_ready_o,
    input  logic [CntW-1:0] cfg_inner_tiles_i,
    input  logic [CntW-1:0] cfg_outer_tiles_i,
    input  logic            inp_valid_i,
    output logic            inp_ready_o,
    input  logic            weight_valid_i,
    output logic            weight_ready_o,
    input  logic            oup_pop_i,
    output logic            calc_en_o,
    output logic            first_inner_tile_o,
    output logic            last_inner_tile_o,
    output logic            busy_o,
    output logic            done_o
`ifdef ITA_TILE_SCHED_PERF_EN
    ,
    output logic [31:0]     stall_cycles_o,
    output logic [31:0]     starve_cycles_o
`endif
);

    localparam int unsigned CredW  = $clog2(FifoDepth + 1);
    localparam int unsigned DrainW = $clog2(PipeDepth + 1);
    localparam logic [CredW-1:0]  CredMax  = CredW'(FifoDepth);
    localparam logic [DrainW-1:0] DrainIni = DrainW'(PipeDepth - 1);

    typedef enum logic [1:0] {
        Idle,
        Run,
        Drain,
        Done
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   inner_tiles_q, inner_tiles_d;
    logic [CntW-1:0]   outer_tiles_q, outer_tiles_d;
    logic [CntW-1:0]   inner_cnt_q, inner_cnt_d;
    logic [CntW-1:0]   outer_cnt_q, outer_cnt_d;
    logic [CredW-1:0]  credits_q, credits_d;
    logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;

    logic both_valid;
    logic is_last;
    logic is_final;
    logic credit_ok;
    logic issue;
    logic credit_dec;

    always_comb begin
        both_valid = inp_valid_i & weight_valid_i;
        is_last    = inner_cnt_q == (inner_tiles_q - CntW'(1));
        is_final   = is_last & (outer_cnt_q == (outer_tiles_q - CntW'(1)));
        credit_ok  = credits_q != '0;
        // Only the last inner tile pushes into the FIFO, so only it needs a credit.
        issue      = (state_q == Run) & both_valid & (~is_last | credit_ok);
        credit_dec = issue & is_last;
    end

    assign calc_en_o          = issue;
    assign inp_ready_o        = issue;
    assign weight_ready_o     = issue;
    assign first_inner_tile_o = issue & (inner_cnt_q == '0);
    assign last_inner_tile_o  = credit_dec;
    assign busy_o             = state_q != Idle;

    always_comb begin
        credits_d = credits_q;
        unique case ({credit_dec, oup_pop_i})
            2'b10: credits_d = credits_q - CredW'(1);
            2'b01: begin
                if (credits_q != CredMax) begin
                    credits_d = credits_q + CredW'(1);
                end
            end
            default: credits_d = credits_q;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        inner_tiles_d = inner_tiles_q;
        outer_tiles_d = outer_tiles_q;
        inner_cnt_d   = inner_cnt_q;
        outer_cnt_d   = outer_cnt_q;
        drain_cnt_d   = drain_cnt_q;
        cfg_ready_o   = 1'b0;
        done_o        = 1'b0;
        unique case (state_q)
            Idle: begin
                cfg_ready_o = 1'b1;
                if (cfg_valid_i) begin
                    inner_tiles_d = cfg_inner_tiles_i;
                    outer_tiles_d = cfg_outer_tiles_i;
                    inner_cnt_d   = '0;
                    outer_cnt_d   = '0;
                    if ((cfg_inner_tiles_i == '0) || (cfg_outer_tiles_i == '0)) begin
                        state_d = Done;
                    end else begin
                        state_d = Run;
                    end
                end
            end
            Run: begin
                if (issue) begin
                    if (is_last) begin
                        inner_cnt_d = '0;
                        outer_cnt_d = outer_cnt_q + CntW'(1);
                    end else begin
                        inner_cnt_d = inner_cnt_q + CntW'(1);
                    end
                    if (is_final) begin
                        outer_cnt_d = '0;
                        drain_cnt_d = DrainIni;
                        state_d     = Drain;
                    end
                end
            end
            Drain: begin
                if (drain_cnt_q == '0) begin
                    state_d = Done;
                end else begin
                    drain_cnt_d = drain_cnt_q - DrainW'(1);
                end
            end
            Done: begin
                done_o  = 1'b1;
                state_d = Idle;
            end
            default: state_d = Idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= Idle;
            inner_tiles_q <= '0;
            outer_tiles_q <= '0;
            inner_cnt_q   <= '0;
            outer_cnt_q   <= '0;
            credits_q     <= CredMax;
            drain_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            inner_tiles_q <= inner_tiles_d;
            outer_tiles_q <= outer_tiles_d;
            inner_cnt_q   <= inner_cnt_d;
            outer_cnt_q   <= outer_cnt_d;
            credits_q     <= credits_d;
            drain_cnt_q   <= drain_cnt_d;
        end
    end

`ifndef SYNTHESIS
    // A pop with every credit already home means the FIFO popped an entry we never pushed.
    credit_overflow_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(oup_pop_i && !credit_dec && (credits_q == CredMax)))
        else $error("credit overflow");
`endif

`ifdef ITA_TILE_SCHED_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] starve_cycles_q, starve_cycles_d;

    always_comb begin
        stall_cycles_d  = stall_cycles_q;
        starve_cycles_d = starve_cycles_q;
        if ((state_q == Idle) && cfg_valid_i) begin
            stall_cycles_d  = '0;
            starve_cycles_d = '0;
        end else if (state_q == Run) begin
            if (both_valid && is_last && !credit_ok && (stall_cycles_q != '1)) begin
                stall_cycles_d = stall_cycles_q + 32'd1;
            end
            if (!both_valid && (starve_cycles_q != '1)) begin
                starve_cycles_d = starve_cycles_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cycles_q  <= '0;
            starve_cycles_q <= '0;
        end else begin
            stall_cycles_q  <= stall_cycles_d;
            starve_cycles_q <= starve_cycles_d;
        end
    end

    assign stall_cycles_o  = stall_cycles_q;
    assign starve_cycles_o = starve_cycles_q;
`endif

endmodule

// File: tb/tb_ita_tile_scheduler.sv
// Bench for ita_tile_scheduler: directed and random steps against a tile-count reference model.
module tb_ita_tile_scheduler;

    localparam int PIPE = 10;
    localparam int FIFO = 8;
    localparam int S_IDLE = 0;
    localparam int S_RUN = 1;
    localparam int S_DRAIN = 2;
    localparam int S_DONE = 3;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       cfg_valid_i = 1'b0;
    logic       cfg_ready_o;
    logic [7:0] cfg_inner_tiles_i = '0;
    logic [7:0] cfg_outer_tiles_i = '0;
    logic       inp_valid_i = 1'b0;
    logic       inp_ready_o;
    logic       weight_valid_i = 1'b0;
    logic       weight_ready_o;
    logic       oup_pop_i = 1'b0;
    logic       calc_en_o;
    logic       first_inner_tile_o;
    logic       last_inner_tile_o;
    logic       busy_o;
    logic       done_o;

    ita_tile_scheduler #(
        .CntW(8),
        .PipeDepth(PIPE),
        .FifoDepth(FIFO)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .cfg_valid_i(cfg_valid_i),
        .cfg_ready_o(cfg_ready_o),
        .cfg_inner_tiles_i(cfg_inner_tiles_i),
        .cfg_outer_tiles_i(cfg_outer_tiles_i),
        .inp_valid_i(inp_valid_i),
        .inp_ready_o(inp_ready_o),
        .weight_valid_i(weight_valid_i),
        .weight_ready_o(weight_ready_o),
        .oup_pop_i(oup_pop_i),
        .calc_en_o(calc_en_o),
        .first_inner_tile_o(first_inner_tile_o),
        .last_inner_tile_o(last_inner_tile_o),
        .busy_o(busy_o),
        .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    wire [7:0] obs = {cfg_ready_o, inp_ready_o, weight_ready_o, calc_en_o,
                      first_inner_tile_o, last_inner_tile_o, busy_o, done_o};

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: tiles issued as a linear count k; position in the
    // reduction is k mod inner.
    int m_state, m_inner, m_outer, m_k, m_wait, m_cred;
    bit e_issue, e_last;
    logic [7:0] exp_o;

    task automatic model_reset();
        m_state = S_IDLE;
        m_k = 0;
        m_wait = 0;
        m_cred = FIFO;
        e_issue = 0;
        e_last = 0;
    endtask

    task automatic model_eval();
        bit first;
        int pos;
        e_issue = 0;
        e_last = 0;
        first = 0;
        if (m_state == S_RUN) begin
            pos = m_k % m_inner;
            e_last = (pos == m_inner - 1);
            first = (pos == 0);
            e_issue = inp_valid_i && weight_valid_i && (!e_last || m_cred > 0);
        end
        exp_o = {m_state == S_IDLE, e_issue, e_issue, e_issue,
                 first && e_issue, e_last && e_issue,
                 m_state != S_IDLE, m_state == S_DONE};
    endtask

    task automatic model_update();
        bit dec;
        dec = e_issue && e_last;
        if (dec && !oup_pop_i) m_cred--;
        else if (!dec && oup_pop_i && m_cred < FIFO) m_cred++;
        case (m_state)
            S_IDLE: if (cfg_valid_i) begin
                m_inner = int'(cfg_inner_tiles_i);
                m_outer = int'(cfg_outer_tiles_i);
                m_k = 0;
                m_state = (m_inner == 0 || m_outer == 0) ? S_DONE : S_RUN;
            end
            S_RUN: if (e_issue) begin
                m_k++;
                if (m_k == m_inner * m_outer) begin
                    m_state = S_DRAIN;
                    m_wait = PIPE;
                end
            end
            S_DRAIN: begin
                m_wait--;
                if (m_wait == 0) m_state = S_DONE;
            end
            default: m_state = S_IDLE;
        endcase
    endtask

    task automatic apply(input bit cv, input int ci, input int co,
                         input bit iv, input bit wv, input bit pp);
        cfg_valid_i = cv;
        cfg_inner_tiles_i = 8'(ci);
        cfg_outer_tiles_i = 8'(co);
        inp_valid_i = iv;
        weight_valid_i = wv;
        oup_pop_i = pp && (m_cred < FIFO);
        #2;
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk_i);
        if (rst_ni) model_update();
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        apply(1, 3, 2, 1, 1, 0);
        checks++;
        if (obs !== 8'h80) begin
            errors++;
            $display("FAIL reset_hold got=%b want=%b", obs, 8'h80);
        end
        advance();
        advance();
        rst_ni = 1'b1;
        apply(0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== exp_o) begin
            errors++;
            $display("FAIL reset_release got=%b want=%b", obs, exp_o);
        end
        advance();
    endtask

    task automatic test_basic();
        int issues = 0;
        int t6 = -1;
        bit fin = 0;
        for (int n = 0; n < 60 && !fin; n++) begin
            apply(n == 0, 3, 2, 1, 1, 0);
            checks++;
            if (obs !== exp_o) begin
                errors++;
                $display("FAIL basic cyc=%0d got=%b want=%b", cyc, obs, exp_o);
            end
            if (calc_en_o) begin
                issues++;
                if (issues == 6) t6 = n;
            end
            if (exp_o[0]) begin
                fin = 1;
                checks++;
                if (n - t6 != PIPE + 1) begin
                    errors++;
                    $display("FAIL basic_done_lat got=%0d want=%0d", n - t6, PIPE + 1);
                end
            end
            advance();
        end
        checks++;
        if (!fin || issues != 6) begin
            errors++;
            $display("FAIL basic_issues got=%0d want=6 fin=%0d", issues, fin);
        end
    endtask

    task automatic test_credit_stall();
        int issues = 0;
        int want;
        bit fin = 0;
        want = m_cred;
        for (int n = 0; n < 60 && !fin; n++) begin
            apply(n == 0, 1, want, 1, 1, 0);
            checks++;
            if (obs !== exp_o) begin
                errors++;
                $display("FAIL drain_credits cyc=%0d got=%b want=%b", cyc, obs, exp_o);
            end
            if (exp_o[0]) fin = 1;
            advance();
        end
        fin = 0;
        for (int n = 0; n < 60 && !fin; n++) begin
            apply(n == 0, 1, 4, 1, 1, n >= 4 && n < 8);
            checks++;
            if (obs !== exp_o) begin
                errors++;
                $display("FAIL credit_stall cyc=%0d got=%b want=%b", cyc, obs, exp_o);
            end
            if (calc_en_o) issues++;
            if (exp_o[0]) fin = 1;
            advance();
        end
        checks++;
        if (!fin || issues != 4) begin
            errors++;
            $display("FAIL credit_stall_issues got=%0d want=4 fin=%0d", issues, fin);
        end
    endtask

    task automatic test_inner_stall();
        int issues = 0;
        bit fin = 0;
        for (int n = 0; n < 60 && !fin; n++) begin
            apply(n == 0, 4, 1, 1, 1, n == 8);
            checks++;
            if (obs !== exp_o) begin
                errors++;
                $display("FAIL inner_stall cyc=%0d got=%b want=%b", cyc, obs, exp_o);
            end
            if (calc_en_o) issues++;
            if (exp_o[0]) fin = 1;
            advance();
        end
        checks++;
        if (!fin || issues != 4) begin
            errors++;
            $display("FAIL inner_stall_issues got=%0d want=4 fin=%0d", issues, fin);
        end
    endtask

    task automatic test_toggle();
        int bad = 0;
        bit fin = 0;
        for (int n = 0; n < 80 && !fin; n++) begin
            apply(n == 0, 2, 3, n[0], 1, 1);
            checks++;
            if (obs !== exp_o) begin
                errors++;
                $display("FAIL toggle cyc=%0d got=%b want=%b", cyc, obs, exp_o);
            end
            if ((inp_ready_o || weight_ready_o) && !inp_valid_i) bad++;
            if (exp_o[0]) fin = 1;
            advance();
        end
        checks++;
        if (!fin || bad != 0) begin
            errors++;
            $display("FAIL toggle_ready got=%0d want=0 fin=%0d", bad, fin);
        end
    endtask

    task automatic test_zero();
        for (int n = 0; n < 6; n++) begin
            if (n < 3) apply(n == 0, 0, 5, 1, 1, 0);
            else apply(n == 3, 4, 0, 1, 1, 0);
            checks++;
            if (obs !== exp_o) begin
                errors++;
                $display("FAIL zero cyc=%0d got=%b want=%b", cyc, obs, exp_o);
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        int issues = 0;
        bit fin = 0;
        for (int n = 0; n < 20 && issues < 2; n++) begin
            apply(n == 0, 3, 2, 1, 1, 0);
            checks++;
            if (obs !== exp_o) begin
                errors++;
                $display("FAIL reset_mid_run cyc=%0d got=%b want=%b", cyc, obs, exp_o);
            end
            if (calc_en_o) issues++;
            advance();
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if (obs !== 8'h80) begin
            errors++;
            $display("FAIL reset_mid_async got=%b want=%b", obs, 8'h80);
        end
        model_reset();
        advance();
        rst_ni = 1'b1;
        issues = 0;
        for (int n = 0; n < 40 && !fin; n++) begin
            apply(n == 0, 2, 1, 1, 1, 0);
            checks++;
            if (obs !== exp_o) begin
                errors++;
                $display("FAIL reset_mid_after cyc=%0d got=%b want=%b", cyc, obs, exp_o);
            end
            if (calc_en_o) issues++;
            if (exp_o[0]) fin = 1;
            advance();
        end
        checks++;
        if (!fin || issues != 2) begin
            errors++;
            $display("FAIL reset_mid_issues got=%0d want=2 fin=%0d", issues, fin);
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 10; s++) begin
            int ci, co, issues;
            bit fin;
            ci = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
            co = $urandom_range(0, 3);
            issues = 0;
            fin = 0;
            for (int n = 0; n < 400 && !fin; n++) begin
                if (n == 0) apply(1, ci, co, $urandom_range(0, 9) < 7,
                                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3);
                else apply($urandom_range(0, 1) == 1, $urandom_range(0, 255),
                           $urandom_range(0, 255), $urandom_range(0, 9) < 7,
                           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3);
                checks++;
                if (obs !== exp_o) begin
                    errors++;
                    $display("FAIL random s=%0d cyc=%0d got=%b want=%b", s, cyc, obs, exp_o);
                end
                if (calc_en_o) issues++;
                if (exp_o[0]) fin = 1;
                advance();
            end
            checks++;
            if (!fin || issues != ci * co) begin
                errors++;
                $display("FAIL random_issues s=%0d got=%0d want=%0d fin=%0d", s, issues, ci * co, fin);
            end
        end
    endtask

    task automatic test_max();
        int issues = 0;
        bit fin = 0;
        for (int n = 0; n < 600 && !fin; n++) begin
            apply(n == 0, 255, 1, 1, 1, 1);
            checks++;
            if (obs !== exp_o) begin
                errors++;
                $display("FAIL max cyc=%0d got=%b want=%b", cyc, obs, exp_o);
            end
            if (calc_en_o) issues++;
            if (exp_o[0]) fin = 1;
            advance();
        end
        checks++;
        if (!fin || issues != 255) begin
            errors++;
            $display("FAIL max_issues got=%0d want=255 fin=%0d", issues, fin);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_credit_stall();
        test_inner_stall();
        test_toggle();
        test_zero();
        test_reset_mid();
        test_random();
        test_max();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
